// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes and divider state type shared across the core
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } div_state_t;

endpackage

// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - sequential unsigned restoring divider using the shared ALU for subtraction
module alu_div_seq
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int ALU_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 ready,
   output logic                 valid,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 div_by_zero,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [ALU_WIDTH-1:0] alu_ctrl,
   input  logic [WIDTH-1:0]     alu_result,
   input  logic                 alu_carry
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [ALU_WIDTH-1:0] CTRL_ADD = ALU_WIDTH'(ALU_ADD);
   localparam logic [ALU_WIDTH-1:0] CTRL_SUB = ALU_WIDTH'(ALU_SUB);

   div_state_t       state;
   logic [WIDTH-1:0] dreg;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH:0]   shifted;
   logic             qbit;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;

   // One restoring step: shift in the next dividend bit and let the ALU trial-subtract the divisor.
   // The shifted-out MSB means the partial remainder already exceeds any WIDTH-bit divisor.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      qbit     = shifted[WIDTH] | alu_carry;
      rem_next = qbit ? alu_result : shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], qbit};
   end

   // Drive the shared ALU only while iterating; otherwise present a quiet ADD of zeros.
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = CTRL_ADD;
      if (state == RUN) begin
         alu_a    = shifted[WIDTH-1:0];
         alu_b    = dreg;
         alu_ctrl = CTRL_SUB;
      end
   end

   assign ready = (state == IDLE);

   // Control FSM with the iteration registers and held result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dreg        <= '0;
         rem         <= '0;
         quo         <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         valid       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     valid       <= 1'b1;
                     state       <= DONE;
                  end else begin
                     dreg  <= divisor;
                     rem   <= '0;
                     quo   <= dividend;
                     cnt   <= '0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  quotient    <= quo_next;
                  remainder   <= rem_next;
                  div_by_zero <= 1'b0;
                  valid       <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               valid <= 1'b0;
               state <= IDLE;
            end
            default: begin
               valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - directed self-checking bench for alu_div_seq with an attached ALU
module tb_alu_div_seq;
   import alu_pkg::*;

   localparam int W = 32;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          ready;
   logic          valid;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [2:0]    alu_ctrl;
   logic [W-1:0]  alu_result;
   logic          alu_carry;

   int n_checks;
   int n_fail;

   alu_div_seq #(.WIDTH(W), .ALU_WIDTH(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .valid       (valid),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_ctrl    (alu_ctrl),
      .alu_result  (alu_result),
      .alu_carry   (alu_carry)
   );

   // Core ALU behaviour: SUB computes A + ~B + 1, carry = no borrow.
   always_comb begin
      logic [W:0] sum;
      sum = '0;
      case (alu_ctrl)
         ALU_ADD: sum = {1'b0, alu_a} + {1'b0, alu_b};
         ALU_SUB: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
         ALU_AND: sum = {1'b0, alu_a & alu_b};
         ALU_OR:  sum = {1'b0, alu_a | alu_b};
         ALU_SLT: sum = {1'b0, 31'd0, ($signed(alu_a) < $signed(alu_b))};
         default: sum = '0;
      endcase
      alu_result = sum[W-1:0];
      alu_carry  = sum[W];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one division from IDLE and collect what the DUT reports.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int cyc, output logic got,
                          output logic valid_next, output logic ready_next,
                          output logic ctrl_moved);
      dividend   = a;
      divisor    = b;
      start      = 1'b1;
      cyc        = 0;
      got        = 1'b0;
      ctrl_moved = 1'b0;
      q = '0; r = '0; dz = 1'b0; valid_next = 1'b0; ready_next = 1'b0;
      while (!got && cyc < 100) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
         if (alu_ctrl !== ALU_ADD) ctrl_moved = 1'b1;
         if (valid === 1'b1) begin
            got = 1'b1;
            q   = quotient;
            r   = remainder;
            dz  = div_by_zero;
         end
      end
      @(posedge clk);
      #1;
      valid_next = valid;
      ready_next = ready;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({ready, valid, div_by_zero} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 100", {ready, valid, div_by_zero});
      end
      n_checks++;
      if (quotient !== '0 || remainder !== '0) begin
         n_fail++;
         $display("FAIL reset_results: got q=%h r=%h expected 0/0", quotient, remainder);
      end
      n_checks++;
      if (alu_a !== '0 || alu_b !== '0 || alu_ctrl !== ALU_ADD) begin
         n_fail++;
         $display("FAIL reset_alu: got a=%h b=%h ctrl=%b expected 0/0/000", alu_a, alu_b, alu_ctrl);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [W-1:0] q, r;
      logic dz, got, vn, rn, cm;
      int cyc;
      run_div(32'd100, 32'd7, q, r, dz, cyc, got, vn, rn, cm);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL basic_timeout: got no valid expected valid within 100 cycles");
      end
      n_checks++;
      if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_100_7: got q=%0d r=%0d dz=%b expected 14/2/0", q, r, dz);
      end
      n_checks++;
      if (cyc !== 33) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d expected 33", cyc);
      end
      n_checks++;
      if (vn !== 1'b0 || rn !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_pulse: got valid=%b ready=%b expected 0/1", vn, rn);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (quotient !== 32'd14 || remainder !== 32'd2) begin
         n_fail++;
         $display("FAIL basic_hold: got q=%0d r=%0d expected 14/2", quotient, remainder);
      end
   endtask

   task automatic test_msb_path();
      logic [W-1:0] q, r;
      logic dz, got, vn, rn, cm;
      int cyc;
      run_div(32'hFFFF_FFFF, 32'h8000_0001, q, r, dz, cyc, got, vn, rn, cm);
      n_checks++;
      if (!got || q !== 32'd1 || r !== 32'h7FFF_FFFE) begin
         n_fail++;
         $display("FAIL msb_path: got q=%h r=%h valid=%b expected 1/7ffffffe/1", q, r, got);
      end
   endtask

   task automatic test_extremes();
      logic [W-1:0] q, r;
      logic dz, got, vn, rn, cm;
      int cyc;
      run_div(32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, cyc, got, vn, rn, cm);
      n_checks++;
      if (!got || q !== 32'd0 || r !== 32'h8000_0000) begin
         n_fail++;
         $display("FAIL small_by_big: got q=%h r=%h valid=%b expected 0/80000000/1", q, r, got);
      end
      run_div(32'hFFFF_FFFF, 32'd1, q, r, dz, cyc, got, vn, rn, cm);
      n_checks++;
      if (!got || q !== 32'hFFFF_FFFF || r !== 32'd0) begin
         n_fail++;
         $display("FAIL div_by_one: got q=%h r=%h valid=%b expected ffffffff/0/1", q, r, got);
      end
   endtask

   task automatic test_div_zero();
      logic [W-1:0] q, r;
      logic dz, got, vn, rn, cm;
      int cyc;
      run_div(32'd1234, 32'd0, q, r, dz, cyc, got, vn, rn, cm);
      n_checks++;
      if (!got || q !== 32'hFFFF_FFFF || r !== 32'd1234 || dz !== 1'b1) begin
         n_fail++;
         $display("FAIL div_zero_result: got q=%h r=%0d dz=%b expected ffffffff/1234/1", q, r, dz);
      end
      n_checks++;
      if (cyc !== 1) begin
         n_fail++;
         $display("FAIL div_zero_latency: got %0d expected 1", cyc);
      end
      n_checks++;
      if (cm !== 1'b0 || alu_ctrl !== ALU_ADD) begin
         n_fail++;
         $display("FAIL div_zero_alu_ctrl: got moved=%b ctrl=%b expected 0/000", cm, alu_ctrl);
      end
      n_checks++;
      if (vn !== 1'b0 || rn !== 1'b1) begin
         n_fail++;
         $display("FAIL div_zero_pulse: got valid=%b ready=%b expected 0/1", vn, rn);
      end
   endtask

   task automatic test_ignored_start();
      int cyc;
      logic got;
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      got = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_ready: got %b expected 0", ready);
      end
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      while (!got && cyc < 100) begin
         if (valid === 1'b1) begin
            got = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      n_checks++;
      if (!got || quotient !== 32'd14 || remainder !== 32'd2 || cyc !== 33) begin
         n_fail++;
         $display("FAIL ignored_start: got q=%0d r=%0d cyc=%0d expected 14/2/33", quotient, remainder, cyc);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ignored_start_ready: got %b expected 1", ready);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] q, r;
      logic dz, got, vn, rn, cm, seen;
      int cyc;
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (ready !== 1'b1 || valid !== 1'b0 || div_by_zero !== 1'b0 ||
          quotient !== '0 || remainder !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got rdy=%b v=%b dz=%b q=%h r=%h expected 1/0/0/0/0",
                  ready, valid, div_by_zero, quotient, remainder);
      end
      n_checks++;
      if (alu_a !== '0 || alu_b !== '0 || alu_ctrl !== ALU_ADD) begin
         n_fail++;
         $display("FAIL mid_reset_alu: got a=%h b=%h ctrl=%b expected 0/0/000", alu_a, alu_b, alu_ctrl);
      end
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (valid === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_no_valid: got valid seen=%b expected 0", seen);
      end
      run_div(32'd9, 32'd3, q, r, dz, cyc, got, vn, rn, cm);
      n_checks++;
      if (!got || q !== 32'd3 || r !== 32'd0 || dz !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset_9_3: got q=%0d r=%0d dz=%b expected 3/0/0", q, r, dz);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      test_reset();
      test_basic();
      test_msb_path();
      test_extremes();
      test_div_zero();
      test_ignored_start();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
